// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers, bursts of up to MAX_BURST words.
// Latency: grant one cycle after valid, word on data_o the cycle after its transfer; backpressure: a held word with data_o_ready low drops req_ready_o at once.
module fifo_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int IDX_WIDTH = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          data_o_valid,
    input  logic                          data_o_ready,
    output logic [IDX_WIDTH-1:0]          grant_o,
    output logic                          busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]   grant_q, grant_d;
    logic [CNT_WIDTH-1:0]   burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   data_vld_q, data_vld_d;

    logic [DATA_WIDTH-1:0]  req_words [NUM_REQ];
    logic                   load_en;
    logic                   cur_valid;
    logic                   xfer;
    logic                   burst_last;
    logic [IDX_WIDTH-1:0]   ptr_next;
    logic                   arb_found;
    logic [IDX_WIDTH-1:0]   arb_idx;
    logic [IDX_WIDTH:0]     arb_cand;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign req_words[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // The output register can take a new word whenever it is empty or draining this cycle.
    assign load_en    = ~data_vld_q | data_o_ready;
    assign cur_valid  = req_valid_i[grant_q];
    assign xfer       = (state_q == GRANT) && cur_valid && load_en;
    assign burst_last = (burst_cnt_q == CNT_WIDTH'(MAX_BURST - 1));
    assign ptr_next   = (grant_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if ((state_q == GRANT) && load_en) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

    // Scan ptr, ptr+1, ... wrapping at NUM_REQ, which need not be a power of two.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        arb_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_cand = {1'b0, ptr_q} + (IDX_WIDTH+1)'(k);
            if (arb_cand >= (IDX_WIDTH+1)'(NUM_REQ)) begin
                arb_cand = arb_cand - (IDX_WIDTH+1)'(NUM_REQ);
            end
            if (!arb_found && req_valid_i[arb_cand[IDX_WIDTH-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        data_d      = data_q;
        data_vld_d  = data_vld_q;

        if (data_vld_q && data_o_ready) begin
            data_vld_d = 1'b0;
        end
        if (xfer) begin
            data_d     = req_words[grant_q];
            data_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d     = arb_idx;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (!cur_valid) begin
                    state_d = IDLE;
                    ptr_d   = ptr_next;
                end else if (load_en) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_last) begin
                        state_d = IDLE;
                        ptr_d   = ptr_next;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            data_q      <= '0;
            data_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
            data_vld_q  <= data_vld_d;
        end
    end

    assign data_o       = data_q;
    assign data_o_valid = data_vld_q;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == GRANT);

endmodule
